// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte shifter.
// The state encoding and edge bookkeeping are common to the controller and its bench.
package spi_pkg;

  localparam int BYTE_W         = 8;
  localparam int EDGE_CNT_W     = 4;
  localparam int EDGES_PER_BYTE = 16;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } state_t;

  // Bit that must appear on MOSI before the first SCK edge.
  function automatic logic first_bit(input logic [BYTE_W-1:0] data, input logic lsb_first);
    return lsb_first ? data[0] : data[BYTE_W-1];
  endfunction

endpackage

// File: rtl/spi_shift_ctrl_if.sv
// Bundles the front-end handshake/config signals and the SPI pin signals.
// master = front end / pads side, slave = the shift controller.
interface spi_shift_ctrl_if #(
  parameter int DIV_W = 8
);
  import spi_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] tx_data;
  logic              cpol;
  logic              cpha;
  logic              lsbfe;
  logic [DIV_W-1:0]  baud_div;
  logic              miso;
  logic              sck;
  logic              mosi;
  logic              ss_n;
  logic              busy;
  logic              done;
  logic [BYTE_W-1:0] rx_data;
  logic              shift_strobe;
  logic              sample_strobe;

  modport master (
    output start, tx_data, cpol, cpha, lsbfe, baud_div, miso,
    input  sck, mosi, ss_n, busy, done, rx_data, shift_strobe, sample_strobe
  );

  modport slave (
    input  start, tx_data, cpol, cpha, lsbfe, baud_div, miso,
    output sck, mosi, ss_n, busy, done, rx_data, shift_strobe, sample_strobe
  );

endinterface

// File: rtl/spi_baud_gen.sv
// SCK half-period divider: counts 0..div and ticks on the terminal count.
// Clearing restarts the half-period so the first tick lands div+1 cycles later.
module spi_baud_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_reg;

  assign tick = (count_reg == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_shift_ctrl.sv
// One-byte SPI master sequencer: SS_N framing, SCK generation in all CPOL/CPHA
// modes, MSB/LSB-first MOSI shifting and MISO capture into rx_data.
module spi_shift_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_shift_ctrl_if.slave         bus
);

  state_t                state_reg, state_next;
  logic                  accept, edge_tick, finish, tick;
  logic                  sample_now, shift_now, trailing;

  logic                  cpol_reg, cpha_reg, lsbfe_reg;
  logic [DIV_W-1:0]      div_reg;
  logic [EDGE_CNT_W-1:0] edge_cnt_reg;
  logic [BYTE_W-1:0]     tx_shift_reg, rx_shift_reg, rx_data_reg;
  logic                  sck_reg, mosi_reg, ss_n_reg, done_reg;

  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .div   (div_reg),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // The tick that ends LEAD already performs edge 0, so XFER covers edges 1..15.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    edge_tick  = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          edge_tick  = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          edge_tick = 1'b1;
          if (edge_cnt_reg == EDGE_CNT_W'(EDGES_PER_BYTE - 1)) state_next = TRAIL;
        end
      end
      TRAIL: begin
        if (tick) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Odd edges are trailing; the first bit is preloaded, hence only 7 shifts.
  assign trailing   = edge_cnt_reg[0];
  assign sample_now = edge_tick && (cpha_reg ? trailing : !trailing);
  assign shift_now  = edge_tick &&
                      (cpha_reg ? (!trailing && (edge_cnt_reg != '0))
                                : ( trailing && (edge_cnt_reg != EDGE_CNT_W'(EDGES_PER_BYTE - 1))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      lsbfe_reg    <= 1'b0;
      div_reg      <= '0;
      edge_cnt_reg <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      sck_reg      <= 1'b0;
      mosi_reg     <= 1'b0;
      ss_n_reg     <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= finish;

      if (state_reg == IDLE) begin
        sck_reg  <= bus.cpol;
        mosi_reg <= 1'b0;
        ss_n_reg <= 1'b1;
        if (accept) begin
          cpol_reg     <= bus.cpol;
          cpha_reg     <= bus.cpha;
          lsbfe_reg    <= bus.lsbfe;
          div_reg      <= bus.baud_div;
          tx_shift_reg <= bus.tx_data;
          rx_shift_reg <= '0;
          edge_cnt_reg <= '0;
          mosi_reg     <= first_bit(bus.tx_data, bus.lsbfe);
          ss_n_reg     <= 1'b0;
        end
      end

      if (edge_tick) begin
        sck_reg      <= ~sck_reg;
        edge_cnt_reg <= edge_cnt_reg + EDGE_CNT_W'(1);
      end

      if (sample_now) begin
        if (lsbfe_reg) rx_shift_reg <= {bus.miso, rx_shift_reg[BYTE_W-1:1]};
        else           rx_shift_reg <= {rx_shift_reg[BYTE_W-2:0], bus.miso};
      end

      if (shift_now) begin
        if (lsbfe_reg) begin
          tx_shift_reg <= {1'b0, tx_shift_reg[BYTE_W-1:1]};
          mosi_reg     <= tx_shift_reg[1];
        end else begin
          tx_shift_reg <= {tx_shift_reg[BYTE_W-2:0], 1'b0};
          mosi_reg     <= tx_shift_reg[BYTE_W-2];
        end
      end

      if (finish) begin
        sck_reg     <= cpol_reg;
        ss_n_reg    <= 1'b1;
        mosi_reg    <= 1'b0;
        rx_data_reg <= rx_shift_reg;
      end
    end
  end

  assign bus.sck           = sck_reg;
  assign bus.mosi          = mosi_reg;
  assign bus.ss_n          = ss_n_reg;
  assign bus.busy          = (state_reg != IDLE);
  assign bus.done          = done_reg;
  assign bus.rx_data       = rx_data_reg;
  assign bus.shift_strobe  = shift_now;
  assign bus.sample_strobe = sample_now;

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Directed bench for spi_shift_ctrl: reset behaviour, three SPI modes and
// back-to-back transfers with start held high.
module tb_spi_shift_ctrl;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_shift_ctrl_if #(.DIV_W(8)) bus_if ();

  spi_shift_ctrl #(.DIV_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in cycle 0; returns at the negedge of the done cycle.
  // miso_mode: 0 = loopback from mosi, 1 = tied high, 2 = slave driving on leading edges.
  task automatic run_xfer(input string name, input logic [7:0] tx, input logic pol,
                          input logic pha, input logic lsb, input logic [7:0] div,
                          input int miso_mode, input logic [7:0] slave_byte,
                          input logic hold, input int exp_cycles,
                          input logic [7:0] exp_rx, input logic [7:0] exp_mosi);
    int         cyc, edges, samples, shifts, sidx;
    logic       prev_sck, leading, seen_done;
    logic [7:0] mbits;
    bus_if.tx_data  = tx;
    bus_if.cpol     = pol;
    bus_if.cpha     = pha;
    bus_if.lsbfe    = lsb;
    bus_if.baud_div = div;
    bus_if.start    = 1'b1;
    if (miso_mode == 1) bus_if.miso = 1'b1;
    else if (miso_mode == 2) bus_if.miso = 1'b0;
    else bus_if.miso = bus_if.mosi;
    cyc = 0; edges = 0; samples = 0; shifts = 0; sidx = 0;
    mbits = 8'h00; seen_done = 1'b0; prev_sck = pol;
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (!hold) bus_if.start = 1'b0;
        chk({name, " ss_n_cycle1"}, 32'(bus_if.ss_n), 32'(1'b0));
        chk({name, " mosi_first"}, 32'(bus_if.mosi), 32'(lsb ? tx[0] : tx[7]));
        chk({name, " busy_cycle1"}, 32'(bus_if.busy), 32'(1'b1));
      end
      if (cyc == 2) begin
        bus_if.tx_data  = ~tx;
        bus_if.lsbfe    = ~lsb;
        bus_if.cpha     = ~pha;
        bus_if.baud_div = div + 8'd3;
      end
      if (bus_if.sample_strobe) samples++;
      if (bus_if.shift_strobe) shifts++;
      if (bus_if.sck !== prev_sck) begin
        edges++;
        leading = (bus_if.sck != pol);
        if (leading != pha) mbits = {mbits[6:0], bus_if.mosi};
        if (leading && miso_mode == 2 && sidx < 8) begin
          bus_if.miso = slave_byte[sidx];
          sidx++;
        end
        prev_sck = bus_if.sck;
      end
      if (miso_mode == 0) bus_if.miso = bus_if.mosi;
      if (bus_if.done) seen_done = 1'b1;
    end
    chk({name, " done_cycle"}, 32'(cyc), 32'(exp_cycles));
    chk({name, " ss_n_done"}, 32'(bus_if.ss_n), 32'(1'b1));
    chk({name, " busy_done"}, 32'(bus_if.busy), 32'(1'b0));
    chk({name, " rx_data"}, 32'(bus_if.rx_data), 32'(exp_rx));
    chk({name, " sck_edges"}, 32'(edges), 32'd16);
    chk({name, " samples"}, 32'(samples), 32'd8);
    chk({name, " shifts"}, 32'(shifts), 32'd7);
    chk({name, " mosi_bits"}, 32'(mbits), 32'(exp_mosi));
    $display("XFER %s tx=0x%02h cycles=%0d rx=0x%02h edges=%0d samples=%0d shifts=%0d mosi=0x%02h",
             name, tx, cyc, bus_if.rx_data, edges, samples, shifts, mbits);
  endtask

  initial begin
    bus_if.start    = 1'b0;
    bus_if.tx_data  = 8'h00;
    bus_if.cpol     = 1'b0;
    bus_if.cpha     = 1'b0;
    bus_if.lsbfe    = 1'b0;
    bus_if.baud_div = 8'd0;
    bus_if.miso     = 1'b0;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    chk("por sck", 32'(bus_if.sck), 32'(1'b0));
    chk("por ss_n", 32'(bus_if.ss_n), 32'(1'b1));
    chk("por busy", 32'(bus_if.busy), 32'(1'b0));
    chk("por done", 32'(bus_if.done), 32'(1'b0));
    chk("por mosi", 32'(bus_if.mosi), 32'(1'b0));
    chk("por rx_data", 32'(bus_if.rx_data), 32'h00);
    chk("por strobes", 32'({bus_if.shift_strobe, bus_if.sample_strobe}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted mid-XFER with D=2.
    bus_if.tx_data  = 8'hFF;
    bus_if.baud_div = 8'd2;
    bus_if.miso     = 1'b1;
    bus_if.start    = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst busy_before", 32'(bus_if.busy), 32'(1'b1));
    rst = 1'b0;
    #1;
    chk("midrst sck", 32'(bus_if.sck), 32'(1'b0));
    chk("midrst ss_n", 32'(bus_if.ss_n), 32'(1'b1));
    chk("midrst busy", 32'(bus_if.busy), 32'(1'b0));
    chk("midrst mosi", 32'(bus_if.mosi), 32'(1'b0));
    chk("midrst done", 32'(bus_if.done), 32'(1'b0));
    chk("midrst rx_data", 32'(bus_if.rx_data), 32'h00);
    $display("RESET mid-transfer sck=%0b ss_n=%0b busy=%0b rx=0x%02h",
             bus_if.sck, bus_if.ss_n, bus_if.busy, bus_if.rx_data);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Mode 0, D=0, MSB first, loopback.
    run_xfer("mode0", 8'hA5, 1'b0, 1'b0, 1'b0, 8'd0, 0, 8'h00, 1'b0, 18, 8'hA5, 8'hA5);

    // Mode 3, D=3, LSB first, slave returns 0x96.
    @(negedge clk);
    bus_if.cpol = 1'b1;
    repeat (2) @(negedge clk);
    chk("mode3 sck_idle", 32'(bus_if.sck), 32'(1'b1));
    run_xfer("mode3", 8'h3C, 1'b1, 1'b1, 1'b1, 8'd3, 2, 8'h96, 1'b0, 69, 8'h96, 8'h3C);

    // Mode 1, D=1, miso tied high.
    @(negedge clk);
    bus_if.cpol = 1'b0;
    repeat (2) @(negedge clk);
    run_xfer("mode1", 8'h5A, 1'b0, 1'b1, 1'b0, 8'd1, 1, 8'h00, 1'b0, 35, 8'hFF, 8'h5A);

    // start held high: ignored while busy, re-accepted in the done cycle.
    @(negedge clk);
    run_xfer("hold_first", 8'hC3, 1'b0, 1'b0, 1'b0, 8'd0, 0, 8'h00, 1'b1, 18, 8'hC3, 8'hC3);
    run_xfer("hold_second", 8'h01, 1'b0, 1'b0, 1'b0, 8'd0, 0, 8'h00, 1'b0, 18, 8'h01, 8'h01);

    @(negedge clk);
    chk("final done_pulse", 32'(bus_if.done), 32'(1'b0));
    chk("final rx_held", 32'(bus_if.rx_data), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
